dma_scheduler: RTL and testbench

- Owns the data-memory write port and shares it between the CPU and CLIENT_NUM DMA clients (button controller first, further DMA sources after).
- On each frame_start pulse, the block does the following:
  - stalls the CPU;
  - starts each client in turn with a one-cycle copy_start;
  - routes that client's write bus to memory until the client finishes;
  - returns the port to the CPU.

---
 rtl/dma_scheduler.sv | 157 +++++++++++++++
 tb/tb_dma_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_scheduler.sv
// Shares the data-memory write port between the CPU and CLIENT_NUM DMA clients, serving each client once per frame.
// Optional overrun reporting is enabled by defining DMA_SCHEDULER_OVERRUN_EN.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 12
`endif

module dma_scheduler #(
  parameter int CLIENT_NUM    = 2,
  parameter int ADDR_WIDTH    = `DATA_ADDR_WIDTH,
  parameter int TIMEOUT       = 64,
  parameter int TIMEOUT_WIDTH = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic                           cpu_we,
  input  logic [ADDR_WIDTH-1:0]          cpu_addr,
  input  logic [15:0]                    cpu_dout,
  output logic                           cpu_stall,
  output logic [CLIENT_NUM-1:0]          dma_copy_start,
  input  logic [CLIENT_NUM-1:0]          dma_we,
  input  logic [CLIENT_NUM*ADDR_WIDTH-1:0] dma_addr,
  input  logic [CLIENT_NUM*16-1:0]       dma_dout,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [15:0]                    mem_din,
  output logic                           busy
`ifdef DMA_SCHEDULER_OVERRUN_EN
  ,
  input  logic                           overrun_clear,
  output logic                           overrun,
  output logic [7:0]                     overrun_count
`endif
);

  localparam int IDX_W = (CLIENT_NUM > 1) ? $clog2(CLIENT_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLIENT_NUM - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, ADVANCE} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic                     seen_we;
  logic [TIMEOUT_WIDTH-1:0] timer;

  logic                     sel_we;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [15:0]              sel_dout;

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_dout = '0;
    for (int k = 0; k < CLIENT_NUM; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_we   = dma_we[k];
        sel_addr = dma_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_dout = dma_dout[k*16 +: 16];
      end
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = sel_addr;
    mem_din  = sel_dout;
    case (state)
      IDLE: begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_din  = cpu_dout;
      end
      RUN:     mem_we = sel_we;
      default: mem_we = 1'b0;
    endcase
  end

  always_comb begin
    dma_copy_start = '0;
    if (state == START) begin
      for (int k = 0; k < CLIENT_NUM; k++) begin
        dma_copy_start[k] = (idx == IDX_W'(k));
      end
    end
  end

  // Stall is decoded straight from the state register so reset releases the CPU without waiting for a clock.
  assign busy      = (state != IDLE);
  assign cpu_stall = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      seen_we <= 1'b0;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= START;
            idx   <= '0;
          end
        end
        START: begin
          seen_we <= 1'b0;
          timer   <= '0;
          state   <= RUN;
        end
        RUN: begin
          if (sel_we) seen_we <= 1'b1;
          // The cycle where a burst drops carries no write, so it doubles as the dead cycle before the next client.
          if (seen_we && !sel_we) begin
            if (idx == LAST_IDX) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= START;
            end
          end else if (!seen_we && (timer == TIMER_LAST)) begin
            state <= ADVANCE;
          end else begin
            timer <= timer + TIMEOUT_WIDTH'(1);
          end
        end
        ADVANCE: begin
          if (idx == LAST_IDX) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_SCHEDULER_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
    end else if (overrun_clear) begin
      overrun       <= 1'b0;
      overrun_count <= 8'd0;
    end else if (frame_start && (state != IDLE)) begin
      overrun <= 1'b1;
      if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_scheduler.sv
// Self-checking bench for dma_scheduler: behavioural DMA clients feed a write scoreboard, and
// each scenario task checks frame timing from per-cycle observations.
module tb_dma_scheduler;

  localparam int AW = 12;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              frame_start;
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [15:0]       cpu_dout;
  logic              cpu_stall;
  logic [NC-1:0]     dma_copy_start;
  logic [NC-1:0]     dma_we;
  logic [NC*AW-1:0]  dma_addr;
  logic [NC*16-1:0]  dma_dout;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [15:0]       mem_din;
  logic              busy;
`ifdef DMA_SCHEDULER_OVERRUN_EN
  logic              overrun_clear;
  logic              overrun;
  logic [7:0]        overrun_count;
`endif

  dma_scheduler #(
    .CLIENT_NUM(NC), .ADDR_WIDTH(AW), .TIMEOUT(64), .TIMEOUT_WIDTH(7)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .dma_copy_start(dma_copy_start), .dma_we(dma_we), .dma_addr(dma_addr), .dma_dout(dma_dout),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy)
`ifdef DMA_SCHEDULER_OVERRUN_EN
    , .overrun_clear(overrun_clear), .overrun(overrun), .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  fails = 0;

  int  burst_len[NC];
  int  sent[NC];
  bit  active[NC];
  int  start_seen[NC];
  int  start_used[NC];

  logic [NC-1:0] obs_cs[0:127];
  bit            obs_we[0:127];
  bit            obs_stall[0:127];
  bit            obs_busy[0:127];
  logic [AW-1:0] obs_addr[0:127];

  // Client k writes addresses 0x100*(k+1)+n with data 0xC000+0x100*k+n.
  function automatic wr_t client_word(input int k, input int n);
    wr_t w;
    w.addr = AW'(32'h100 * (k + 1) + n);
    w.data = 16'(32'hC000 + 32'h100 * k + n);
    return w;
  endfunction

  task automatic drive_clients();
    wr_t w;
    dma_we   = '0;
    dma_addr = '0;
    dma_dout = '0;
    for (int k = 0; k < NC; k++) begin
      if (start_seen[k] != start_used[k]) begin
        start_used[k] = start_seen[k];
        active[k] = 1'b1;
        sent[k] = 0;
      end
      if (active[k]) begin
        if (sent[k] < burst_len[k]) begin
          w = client_word(k, sent[k]);
          dma_we[k] = 1'b1;
          dma_addr[k*AW +: AW] = w.addr;
          dma_dout[k*16 +: 16] = w.data;
          exp_q.push_back(w);
          sent[k]++;
        end else begin
          active[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic sample_cycle();
    wr_t e;
    @(negedge clk);
    if (reset) begin
      for (int k = 0; k < NC; k++) if (dma_copy_start[k]) start_seen[k]++;
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL scoreboard_write: got addr=%h data=%h, expected no write", mem_addr, mem_din);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_din !== e.data) begin
            fails++;
            $display("[TB] FAIL scoreboard_write: got addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_din, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    frame_start = 1'b0;
    cpu_we = 1'b0;
`ifdef DMA_SCHEDULER_OVERRUN_EN
    overrun_clear = 1'b0;
`endif
    drive_clients();
    sample_cycle();
  endtask

  // Cycle 0 carries the accepted frame_start; extra pulses and a held CPU write are optional.
  task automatic run_frame(input int len0, input int len1, input int ncyc,
                           input int fs_a, input int fs_b, input int cpu_until);
    burst_len[0] = len0;
    burst_len[1] = len1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      frame_start = (c == 0) || (c == fs_a) || (c == fs_b);
      if (cpu_until > 0 && c >= 1 && c <= cpu_until) begin
        cpu_we = 1'b1;
        cpu_addr = 12'h3F0;
        cpu_dout = 16'h5555;
        if (c == cpu_until) exp_q.push_back({12'h3F0, 16'h5555});
      end else begin
        cpu_we = 1'b0;
      end
      drive_clients();
      sample_cycle();
      obs_cs[c] = dma_copy_start;
      obs_we[c] = mem_we;
      obs_stall[c] = cpu_stall;
      obs_busy[c] = busy;
      obs_addr[c] = mem_addr;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cpu_stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b expected 0", cpu_stall); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (dma_copy_start !== 2'b00) begin fails++; $display("[TB] FAIL reset_copy_start: got %b expected 00", dma_copy_start); end
    @(posedge clk); #1;
    reset = 1'b1;
    sample_cycle();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_cpu_write();
    @(posedge clk); #1;
    cpu_we = 1'b1;
    cpu_addr = 12'h010;
    cpu_dout = 16'h1234;
    exp_q.push_back({12'h010, 16'h1234});
    drive_clients();
    sample_cycle();
    checks++; if (mem_we !== 1'b1) begin fails++; $display("[TB] FAIL cpu_mem_we: got %b expected 1", mem_we); end
    checks++; if (mem_addr !== 12'h010) begin fails++; $display("[TB] FAIL cpu_mem_addr: got %h expected 010", mem_addr); end
    checks++; if (mem_din !== 16'h1234) begin fails++; $display("[TB] FAIL cpu_mem_din: got %h expected 1234", mem_din); end
    checks++; if (cpu_stall !== 1'b0) begin fails++; $display("[TB] FAIL cpu_stall_idle: got %b expected 0", cpu_stall); end
    idle_cycle();
  endtask

  task automatic test_two_clients();
    int n = 0;
    run_frame(4, 2, 13, -1, -1, 0);
    for (int c = 2; c <= 5; c++) if (obs_we[c]) n++;
    checks++; if (obs_cs[1] !== 2'b01) begin fails++; $display("[TB] FAIL two_cs0: got %b expected 01", obs_cs[1]); end
    checks++; if (obs_cs[2] !== 2'b00) begin fails++; $display("[TB] FAIL two_cs0_width: got %b expected 00", obs_cs[2]); end
    checks++; if (n != 4) begin fails++; $display("[TB] FAIL two_burst0: got %0d writes expected 4", n); end
    checks++; if (obs_we[6] !== 1'b0) begin fails++; $display("[TB] FAIL two_dead0: got %b expected 0", obs_we[6]); end
    checks++; if (obs_cs[7] !== 2'b10) begin fails++; $display("[TB] FAIL two_cs1: got %b expected 10", obs_cs[7]); end
    checks++; if (!(obs_we[8] && obs_we[9])) begin fails++; $display("[TB] FAIL two_burst1: got %b%b expected 11", obs_we[8], obs_we[9]); end
    checks++; if (obs_stall[10] !== 1'b1) begin fails++; $display("[TB] FAIL two_stall_t10: got %b expected 1", obs_stall[10]); end
    checks++; if (obs_stall[11] !== 1'b0) begin fails++; $display("[TB] FAIL two_stall_t11: got %b expected 0", obs_stall[11]); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL two_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int n = 0;
    run_frame(2, 0, 74, -1, -1, 0);
    for (int c = 5; c <= 70; c++) if (obs_we[c]) n++;
    checks++; if (obs_cs[5] !== 2'b10) begin fails++; $display("[TB] FAIL timeout_cs1: got %b expected 10", obs_cs[5]); end
    checks++; if (n != 0) begin fails++; $display("[TB] FAIL timeout_mem_we: got %0d writes expected 0", n); end
    checks++; if (obs_busy[70] !== 1'b1) begin fails++; $display("[TB] FAIL timeout_busy70: got %b expected 1", obs_busy[70]); end
    checks++; if (obs_busy[71] !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy71: got %b expected 0", obs_busy[71]); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL timeout_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_cpu_hold();
    int n = 0;
    run_frame(1, 1, 9, -1, -1, 7);
    for (int c = 1; c <= 6; c++) if (obs_we[c] && obs_addr[c] == 12'h3F0) n++;
    checks++; if (n != 0) begin fails++; $display("[TB] FAIL hold_leak: got %0d cpu writes expected 0", n); end
    checks++; if (obs_stall[6] !== 1'b1) begin fails++; $display("[TB] FAIL hold_stall6: got %b expected 1", obs_stall[6]); end
    checks++; if (obs_stall[7] !== 1'b0) begin fails++; $display("[TB] FAIL hold_stall7: got %b expected 0", obs_stall[7]); end
    checks++; if (!(obs_we[7] && obs_addr[7] == 12'h3F0)) begin fails++; $display("[TB] FAIL hold_release: got we=%b addr=%h expected we=1 addr=3f0", obs_we[7], obs_addr[7]); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL hold_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    run_frame(4, 2, 14, 3, 10, 0);
    for (int c = 0; c < 14; c++) if (obs_cs[c] != 2'b00) pulses++;
    checks++; if (pulses != 2) begin fails++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses); end
    checks++; if (obs_busy[11] !== 1'b0 || obs_busy[12] !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle: got %b%b expected 00", obs_busy[11], obs_busy[12]); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL b2b_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    run_frame(6, 2, 5, -1, -1, 0);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin fails++; $display("[TB] FAIL midrst_stall: got %b expected 0", cpu_stall); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (mem_we !== 1'b0) begin fails++; $display("[TB] FAIL midrst_mem_we: got %b expected 0", mem_we); end
    dma_we = '0;
    for (int k = 0; k < NC; k++) begin
      active[k] = 1'b0;
      start_used[k] = start_seen[k];
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    sample_cycle();
    run_frame(2, 1, 9, -1, -1, 0);
    checks++; if (obs_cs[1] !== 2'b01) begin fails++; $display("[TB] FAIL midrst_restart: got %b expected 01", obs_cs[1]); end
    checks++; if (!(obs_we[2] && obs_addr[2] == 12'h100)) begin fails++; $display("[TB] FAIL midrst_first: got we=%b addr=%h expected we=1 addr=100", obs_we[2], obs_addr[2]); end
    checks++; if (obs_busy[8] !== 1'b0) begin fails++; $display("[TB] FAIL midrst_done: got %b expected 0", obs_busy[8]); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL midrst_leftover: got %0d pending expected 0", exp_q.size()); end
  endtask

`ifdef DMA_SCHEDULER_OVERRUN_EN
  task automatic test_overrun();
    @(posedge clk); #1;
    overrun_clear = 1'b1;
    drive_clients();
    sample_cycle();
    idle_cycle();
    checks++; if (overrun !== 1'b0 || overrun_count !== 8'd0) begin fails++; $display("[TB] FAIL ovr_preclear: got %b/%0d expected 0/0", overrun, overrun_count); end
    run_frame(2, 1, 12, 3, 4, 0);
    checks++; if (overrun !== 1'b1) begin fails++; $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); end
    checks++; if (overrun_count !== 8'd2) begin fails++; $display("[TB] FAIL ovr_count: got %0d expected 2", overrun_count); end
    @(posedge clk); #1;
    overrun_clear = 1'b1;
    drive_clients();
    sample_cycle();
    idle_cycle();
    checks++; if (overrun !== 1'b0 || overrun_count !== 8'd0) begin fails++; $display("[TB] FAIL ovr_clear: got %b/%0d expected 0/0", overrun, overrun_count); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    frame_start = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_dout = '0;
    dma_we = '0;
    dma_addr = '0;
    dma_dout = '0;
`ifdef DMA_SCHEDULER_OVERRUN_EN
    overrun_clear = 1'b0;
`endif
    for (int k = 0; k < NC; k++) begin
      burst_len[k] = 0;
      sent[k] = 0;
      active[k] = 1'b0;
      start_seen[k] = 0;
      start_used[k] = 0;
    end
    test_reset();
    test_cpu_write();
    test_two_clients();
    idle_cycle();
    test_timeout();
    idle_cycle();
    test_cpu_hold();
    idle_cycle();
    test_back_to_back();
    idle_cycle();
    test_reset_mid_burst();
    idle_cycle();
`ifdef DMA_SCHEDULER_OVERRUN_EN
    test_overrun();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
